// File: rtl/fifo_wptr_full_if.sv
// Write-side bundle between the producer, the write-pointer/full controller
// and the dual-port RAM write port.
interface fifo_wptr_full_if #(
    parameter int n = 4
);
    // winc is a request. A write is accepted in exactly those cycles where wen
    // (winc & ~wfull) is high. A winc presented while full is dropped and
    // recorded in wovf. The producer never waits on an acknowledge.
    logic         winc;
    logic [n-1:0] wq2_rptr;
    logic         wovf_clr;
    logic         wen;
    logic [n-2:0] waddr;
    logic [n-1:0] wptr;
    logic         wfull;
    logic         walmost_full;
    logic [n-1:0] wlevel;
    logic         wovf;

    modport master (
        output winc, wq2_rptr, wovf_clr,
        input  wen, waddr, wptr, wfull, walmost_full, wlevel, wovf
    );

    modport slave (
        input  winc, wq2_rptr, wovf_clr,
        output wen, waddr, wptr, wfull, walmost_full, wlevel, wovf
    );
endinterface

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full/almost-full/level/overflow logic for the async FIFO.
// Compares the next Gray write pointer with the synchronised Gray read pointer.
module fifo_wptr_full #(
    parameter int n         = 4,
    parameter int AF_THRESH = (2 ** (n - 1)) - 2
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    fifo_wptr_full_if.slave       bus
);
    localparam logic [n-1:0] AF_T = AF_THRESH[n-1:0];

    logic [n-1:0] wbin;
    logic [n-1:0] wbnext;
    logic [n-1:0] wgnext;
    logic [n-1:0] rbin;
    logic [n-1:0] lvl_next;
    logic         wfull_val;
    logic         wen_int;

    assign wen_int = bus.winc & ~bus.wfull;
    assign bus.wen = wen_int;
    assign bus.waddr = wbin[n-2:0];

    assign wbnext = wbin + {{(n - 1){1'b0}}, wen_int};
    assign wgnext = (wbnext >> 1) ^ wbnext;

    // Full means the write pointer is exactly one lap ahead of the read pointer.
    assign wfull_val = (wgnext == {~bus.wq2_rptr[n-1:n-2], bus.wq2_rptr[n-3:0]});

    always_comb begin
        rbin = '0;
        rbin[n-1] = bus.wq2_rptr[n-1];
        for (int i = n - 2; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ bus.wq2_rptr[i];
        end
    end

    assign lvl_next = wbnext - rbin;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin             <= '0;
            bus.wptr         <= '0;
            bus.wfull        <= 1'b0;
            bus.walmost_full <= 1'b0;
            bus.wlevel       <= '0;
            bus.wovf         <= 1'b0;
        end else begin
            wbin             <= wbnext;
            bus.wptr         <= wgnext;
            bus.wfull        <= wfull_val;
            bus.walmost_full <= (lvl_next >= AF_T);
            bus.wlevel       <= lvl_next;
            // A new overflow in the clearing cycle takes priority over the clear.
            bus.wovf         <= (bus.wovf & ~bus.wovf_clr) | (bus.winc & bus.wfull);
        end
    end
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full: a write/read-count model predicts every
// cycle's outputs, a negedge monitor pops and compares.
module tb_fifo_wptr_full;
    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    typedef struct packed {
        logic       wen;
        logic [2:0] waddr;
        logic [3:0] wptr;
        logic       wfull;
        logic       waf;
        logic [3:0] wlevel;
        logic       wovf;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic wclk = 1'b0;
    logic wrst_n = 1'b0;

    fifo_wptr_full_if #(.n(N)) bus ();

    fifo_wptr_full #(.n(N), .AF_THRESH(AF)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    always #5 wclk = ~wclk;

    int total = 0;
    int bad = 0;
    logic [EXP_W-1:0] exp_q[$];

    // Reference model: absolute counts of writes accepted and reads visible.
    int   m_wr = 0;
    int   m_rd = 0;
    logic m_full = 1'b0;
    logic m_ovf = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [3:0] gray(input int b);
        logic [3:0] x;
        x = b[3:0];
        return x ^ (x >> 1);
    endfunction

    function automatic exp_t cur_exp(input logic wi);
        exp_t e;
        e.wen    = wi & ~m_full;
        e.waddr  = 3'(m_wr % DEPTH);
        e.wptr   = gray(m_wr % 16);
        e.wfull  = m_full;
        e.waf    = (m_wr - m_rd) >= AF;
        e.wlevel = 4'(m_wr - m_rd);
        e.wovf   = m_ovf;
        return e;
    endfunction

    // Monitor: the outputs of each cycle are compared mid-cycle.
    exp_t mon_e;
    always @(negedge wclk) begin
        if (wrst_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("wen",          int'(bus.wen),          int'(mon_e.wen));
            chk("waddr",        int'(bus.waddr),        int'(mon_e.waddr));
            chk("wptr",         int'(bus.wptr),         int'(mon_e.wptr));
            chk("wfull",        int'(bus.wfull),        int'(mon_e.wfull));
            chk("walmost_full", int'(bus.walmost_full), int'(mon_e.waf));
            chk("wlevel",       int'(bus.wlevel),       int'(mon_e.wlevel));
            chk("wovf",         int'(bus.wovf),         int'(mon_e.wovf));
        end
    end

    // Driver: apply one cycle of inputs, queue the expected view, advance model.
    task automatic step(input logic wi, input int rd, input logic clr);
        logic ovf_n;
        bus.winc     = wi;
        bus.wq2_rptr = gray(rd % 16);
        bus.wovf_clr = clr;
        exp_q.push_back(cur_exp(wi));
        ovf_n = (wi && m_full) || (m_ovf && !clr);
        if (wi && !m_full) m_wr++;
        m_rd   = rd;
        m_full = (m_wr - m_rd) == DEPTH;
        m_ovf  = ovf_n;
        @(posedge wclk);
        #1;
    endtask

    task automatic chk_cleared(input string tag, input int wen_req);
        chk({tag, "_wen"},    int'(bus.wen),          wen_req);
        chk({tag, "_waddr"},  int'(bus.waddr),        0);
        chk({tag, "_wptr"},   int'(bus.wptr),         0);
        chk({tag, "_wfull"},  int'(bus.wfull),        0);
        chk({tag, "_waf"},    int'(bus.walmost_full), 0);
        chk({tag, "_wlevel"}, int'(bus.wlevel),       0);
        chk({tag, "_wovf"},   int'(bus.wovf),         0);
    endtask

    // Called just after a rising edge: reset is pulsed and released between edges.
    task automatic pulse_reset(input string tag);
        bus.winc     = 1'b0;
        bus.wovf_clr = 1'b0;
        bus.wq2_rptr = '0;
        #1 wrst_n = 1'b0;
        #1 chk_cleared(tag, 0);
        wrst_n = 1'b1;
        m_wr = 0;
        m_rd = 0;
        m_full = 1'b0;
        m_ovf = 1'b0;
        @(posedge wclk);
        #1;
    endtask

    initial begin
        bus.winc     = 1'b1;
        bus.wq2_rptr = 4'b0110;
        bus.wovf_clr = 1'b0;
        #3 chk_cleared("rst", 1);
        @(posedge wclk);
        #1 chk_cleared("rst_edge", 1);
        bus.winc     = 1'b0;
        bus.wq2_rptr = '0;
        #1 wrst_n = 1'b1;
        @(posedge wclk);
        #1;

        // Fill to full, then one rejected write.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 0, 1'b0);
        step(1'b1, 0, 1'b0);
        step(1'b0, 0, 1'b0);

        // Drain one entry, refill.
        step(1'b0, 1, 1'b0);
        step(1'b1, 1, 1'b0);
        step(1'b0, 1, 1'b0);

        // Overflow clear when not full, then clear colliding with a new overflow.
        step(1'b0, 2, 1'b1);
        step(1'b1, 2, 1'b0);
        step(1'b1, 2, 1'b0);
        step(1'b1, 2, 1'b0);
        step(1'b1, 2, 1'b1);
        step(1'b0, 2, 1'b0);

        // Wrap with the reader two entries behind.
        pulse_reset("rst_wrap");
        step(1'b1, 0, 1'b0);
        step(1'b1, 0, 1'b0);
        for (int i = 0; i < 44; i++) step(1'b1, m_wr - 1, 1'b0);
        step(1'b0, m_wr - 2, 1'b0);

        // Random producer and reader traffic.
        for (int i = 0; i < 400; i++) begin
            int avail;
            int adv;
            avail = m_wr - m_rd;
            adv = $urandom_range(0, 2);
            if (adv > avail) adv = avail;
            step(1'($urandom_range(0, 3) != 0), m_rd + adv, 1'($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset in the middle of a fill.
        pulse_reset("rst_pre");
        for (int i = 0; i < 5; i++) step(1'b1, 0, 1'b0);
        pulse_reset("rst_mid");
        for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b0);
        step(1'b0, 0, 1'b0);

        @(posedge wclk);
        #1 chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
